// File: rtl/match_timer.sv
// Prescaled one-second timer: counts whole seconds up to a latched limit, with
// pause/restart/clear, one-shot or periodic mode and a one-cycle done pulse.
module match_timer #(
    parameter int PRESCALE = 50,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             mode,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic             expired
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    state_t           r_state;
    logic [PS_W-1:0]  r_presc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_limit;
    logic             r_mode;
    logic             r_tick;
    logic             r_done;
    logic             r_expired;

    logic w_last_presc;
    logic w_last_sec;

    assign w_last_presc = (r_presc == PS_W'(PRESCALE - 1));
    assign w_last_sec   = (r_count == r_limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_count   <= '0;
            r_limit   <= '0;
            r_mode    <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            if (clear) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_count   <= '0;
                r_expired <= 1'b0;
            end else if (start) begin
                r_state   <= S_RUN;
                r_limit   <= (limit == '0) ? CNT_W'(1) : limit;
                r_mode    <= mode;
                r_presc   <= '0;
                r_count   <= '0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    // Releasing pause advances the prescaler on that same edge,
                    // so only the cycles with pause high are lost.
                    S_RUN, S_PAUSED: begin
                        if (pause) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_state <= S_RUN;
                            if (w_last_presc) begin
                                r_presc <= '0;
                                r_tick  <= 1'b1;
                                if (w_last_sec) begin
                                    r_done <= 1'b1;
                                    if (r_mode) begin
                                        r_count <= '0;
                                    end else begin
                                        r_count   <= r_limit;
                                        r_state   <= S_EXPIRED;
                                        r_expired <= 1'b1;
                                    end
                                end else begin
                                    r_count <= r_count + CNT_W'(1);
                                end
                            end else begin
                                r_presc <= r_presc + PS_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign done    = r_done;
    assign expired = r_expired;
    assign busy    = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule

// File: tb/tb_match_timer.sv
// Self-checking bench for match_timer (PRESCALE=4, CNT_W=8): expected done edges
// are queued when a run is started and matched against observed done pulses.
module tb_match_timer;

    localparam int PS = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, pause, clear, mode;
    logic [CW-1:0] limit;
    logic [CW-1:0] count;
    logic          tick, done, busy, expired;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int e0     = 0;
    int k      = 0;
    int exp_c  = 0;
    int mon_exp;
    int done_q[$];

    match_timer #(.PRESCALE(PS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
        .mode(mode), .limit(limit), .count(count), .tick(tick), .done(done),
        .busy(busy), .expired(expired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest expected done edge.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                $display("FAIL done_unexpected: got done at edge %0d, required none", cyc);
            end else begin
                mon_exp = done_q.pop_front();
                if (cyc !== mon_exp) $display("FAIL done_time: got edge %0d, required %0d", cyc, mon_exp);
                else passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lim, input logic m);
        start = 1'b1; limit = CW'(lim); mode = m;
        step();
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic check_q_empty(input string name);
        checks++;
        if (done_q.size() != 0) $display("FAIL %s_missing_done: got %0d pending, required 0", name, done_q.size());
        else passed++;
        done_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; limit = 8'd3;
        step(); step();
        checks++;
        if ({count, tick, done, busy, expired} !== '0)
            $display("FAIL reset_outputs: got %h, required 0", {count, tick, done, busy, expired});
        else passed++;
        rst_n = 1'b1; start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: got busy %b, required 0", busy);
        else passed++;
    endtask

    task automatic test_oneshot();
        do_start(3, 1'b0);
        done_q.push_back(e0 + 12);
        for (int i = 0; i < 16; i++) begin
            step();
            k = cyc - e0;
            exp_c = (k / PS > 3) ? 3 : k / PS;
            checks++;
            if (count !== CW'(exp_c)) $display("FAIL oneshot_count k=%0d: got %0d, required %0d", k, count, exp_c);
            else passed++;
            checks++;
            if (tick !== (k % PS == 0 && k <= 12)) $display("FAIL oneshot_tick k=%0d: got %b", k, tick);
            else passed++;
            checks++;
            if (busy !== (k < 12) || expired !== (k >= 12))
                $display("FAIL oneshot_state k=%0d: got busy %b expired %b", k, busy, expired);
            else passed++;
        end
        check_q_empty("oneshot");
    endtask

    task automatic test_periodic();
        do_start(2, 1'b1);
        done_q.push_back(e0 + 8);
        done_q.push_back(e0 + 16);
        done_q.push_back(e0 + 24);
        for (int i = 0; i < 26; i++) begin
            step();
            k = cyc - e0;
            exp_c = (k / PS) % 2;
            checks++;
            if (count !== CW'(exp_c)) $display("FAIL periodic_count k=%0d: got %0d, required %0d", k, count, exp_c);
            else passed++;
            checks++;
            if (busy !== 1'b1 || expired !== 1'b0)
                $display("FAIL periodic_state k=%0d: got busy %b expired %b, required 1 0", k, busy, expired);
            else passed++;
        end
        clear = 1'b1; step(); clear = 1'b0;
        check_q_empty("periodic");
    endtask

    task automatic test_pause();
        do_start(3, 1'b0);
        done_q.push_back(e0 + 17);
        step();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (count !== '0 || tick !== 1'b0 || busy !== 1'b1)
                $display("FAIL pause_frozen: got count %0d tick %b busy %b, required 0 0 1", count, tick, busy);
            else passed++;
        end
        pause = 1'b0;
        while (cyc - e0 < 17) step();
        checks++;
        if (count !== 8'd3 || expired !== 1'b1) $display("FAIL pause_end: got count %0d expired %b, required 3 1", count, expired);
        else passed++;
        step();
        check_q_empty("pause");

        // Pause rising on a would-be tick edge swallows that tick.
        do_start(3, 1'b0);
        done_q.push_back(e0 + 13);
        step(); step(); step();
        pause = 1'b1;
        step();
        checks++;
        if (tick !== 1'b0 || count !== '0) $display("FAIL pause_suppress: got tick %b count %0d, required 0 0", tick, count);
        else passed++;
        pause = 1'b0;
        step();
        checks++;
        if (tick !== 1'b1 || count !== 8'd1) $display("FAIL pause_resume: got tick %b count %0d, required 1 1", tick, count);
        else passed++;
        while (cyc - e0 < 14) step();
        check_q_empty("pause_edge");
    endtask

    task automatic test_restart_clear();
        do_start(3, 1'b0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (count !== 8'd2) $display("FAIL restart_pre: got count %0d, required 2", count);
        else passed++;
        do_start(3, 1'b1);
        checks++;
        if (count !== '0 || busy !== 1'b1) $display("FAIL restart_zero: got count %0d busy %b, required 0 1", count, busy);
        else passed++;
        done_q.push_back(e0 + 12);
        for (int i = 0; i < 13; i++) begin
            step();
            k = cyc - e0;
            exp_c = (k / PS) % 3;
            checks++;
            if (count !== CW'(exp_c) || expired !== 1'b0)
                $display("FAIL restart_count k=%0d: got %0d exp %b, required %0d 0", k, count, expired, exp_c);
            else passed++;
        end
        check_q_empty("restart");
        clear = 1'b1; step(); clear = 1'b0;
        checks++;
        if (count !== '0 || busy !== 1'b0 || tick !== 1'b0) $display("FAIL clear_idle: got count %0d busy %b tick %b, required 0 0 0", count, busy, tick);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL clear_no_done: got done %b busy %b, required 0 0", done, busy);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_start(3, 1'b0);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0; start = 1'b1;
        step();
        checks++;
        if ({count, tick, done, busy, expired} !== '0) $display("FAIL reset_mid: got %h, required 0", {count, tick, done, busy, expired});
        else passed++;
        rst_n = 1'b1; start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_start_ignored: got busy %b, required 0", busy);
        else passed++;
        do_start(1, 1'b0);
        done_q.push_back(e0 + 4);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (expired !== 1'b1) $display("FAIL reset_pre_expired: got %b, required 1", expired);
        else passed++;
        check_q_empty("reset_exp");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({count, tick, done, busy, expired} !== '0) $display("FAIL reset_expired: got %h, required 0", {count, tick, done, busy, expired});
        else passed++;
    endtask

    task automatic test_limits();
        do_start(0, 1'b0);
        done_q.push_back(e0 + 4);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (count !== 8'd1 || expired !== 1'b1) $display("FAIL limit0: got count %0d expired %b, required 1 1", count, expired);
        else passed++;
        check_q_empty("limit0");

        do_start(255, 1'b0);
        done_q.push_back(e0 + 1020);
        for (int i = 0; i < 1026; i++) begin
            step();
            k = cyc - e0;
            exp_c = (k / PS > 255) ? 255 : k / PS;
            checks++;
            if (count !== CW'(exp_c)) $display("FAIL limit255_count k=%0d: got %0d, required %0d", k, count, exp_c);
            else passed++;
        end
        checks++;
        if (expired !== 1'b1 || busy !== 1'b0) $display("FAIL limit255_end: got expired %b busy %b, required 1 0", expired, busy);
        else passed++;
        check_q_empty("limit255");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; mode = 1'b0; limit = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_restart_clear();
        test_reset_mid();
        test_limits();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
